// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: sequencer for one neuron, out = b + sum(x[i]*w[i]).
// A single combinational MAC is reused once per x/w pair, with the running
// accumulator fed back as its bias input. x/w come from synchronous-read
// buffers (data one cycle after rd_en); the result leaves on valid/ready.
// Optional feature: define NEURON_RELU_EN to clamp negative results to zero
// on the output register only (the internal accumulator is unaffected).

// Fixed-point MAC in the Q(SIGN_BIT.INTE_WIDTH.FRAC_WIDTH) format.
// The product is truncated (floor) back to FRAC_WIDTH fractional bits and
// added to the bias at full width. The result keeps the sign of the exact
// sum and the low INTE_WIDTH+FRAC_WIDTH magnitude bits: no saturation, no
// rounding.
module neuron_mac #(
  parameter int INTE_WIDTH = 1,
  parameter int SIGN_BIT   = 1,
  parameter int FRAC_WIDTH = 2,
  localparam int W = SIGN_BIT + INTE_WIDTH + FRAC_WIDTH
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] w,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] result
);

  localparam int PW = 2 * W;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] w_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_trunc;
  logic signed [SW-1:0] sum;

  // Wide multiply-add, then rebuild a W-bit word from the exact sign and the low magnitude bits
  always_comb begin
    x_ext      = {{W{x[W-1]}}, x};
    w_ext      = {{W{w[W-1]}}, w};
    prod       = x_ext * w_ext;
    prod_trunc = prod >>> FRAC_WIDTH;
    sum        = {prod_trunc[PW-1], prod_trunc} + {{(SW-W){b[W-1]}}, b};
    result     = {{SIGN_BIT{sum[SW-1]}}, sum[INTE_WIDTH+FRAC_WIDTH-1:0]};
  end

endmodule

module neuron_seq_ctrl #(
  parameter int INTE_WIDTH = 1,
  parameter int SIGN_BIT   = 1,
  parameter int FRAC_WIDTH = 2,
  parameter int N_INPUTS   = 4,
  localparam int W      = SIGN_BIT + INTE_WIDTH + FRAC_WIDTH,
  localparam int ADDR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] bias_in,
  output logic                busy,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic signed [W-1:0] x_rd_data,
  input  logic signed [W-1:0] w_rd_data,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  // idx must be able to hold N_INPUTS itself, meaning "all reads issued"
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] IDX_END = CNT_W'(N_INPUTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    idx;
  logic signed [W-1:0] acc;
  logic                dv;

  logic                handshake;
  logic                accept;
  logic                run_issue;
  logic                last_pair;
  logic signed [W-1:0] mac_result;
  logic signed [W-1:0] out_next;

  neuron_mac #(
    .INTE_WIDTH (INTE_WIDTH),
    .SIGN_BIT   (SIGN_BIT),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_mac (
    .x      (x_rd_data),
    .w      (w_rd_data),
    .b      (acc),
    .result (mac_result)
  );

  // Job acceptance, read issue and last-pair detection; read 0 goes out in the acceptance cycle
  always_comb begin
    handshake = (state == S_DONE) && out_valid && out_ready;
    accept    = ((state == S_IDLE) && start) || (handshake && start);
    run_issue = (state == S_RUN) && (idx < IDX_END);
    last_pair = (state == S_RUN) && dv && (idx == IDX_END);
    rd_en     = accept || run_issue;
    rd_addr   = run_issue ? idx[ADDR_W-1:0] : '0;
  end

  // Output value on entry to DONE, optionally rectified
  always_comb begin
`ifdef NEURON_RELU_EN
    out_next = mac_result[W-1] ? '0 : mac_result;
`else
    out_next = mac_result;
`endif
  end

  // Sequencer FSM, accumulator and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      dv        <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      dv <= rd_en;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= bias_in;
            idx   <= CNT_W'(1);
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (run_issue) begin
            idx <= idx + CNT_W'(1);
          end
          if (dv) begin
            acc <= mac_result;
          end
          if (last_pair) begin
            out_data  <= out_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (start) begin
              acc   <= bias_in;
              idx   <= CNT_W'(1);
              state <= S_RUN;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed testbench for neuron_seq_ctrl: one instance with N_INPUTS=4 and
// one with N_INPUTS=1, each fed by a synchronous-read x/w buffer model.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_neuron_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

`ifdef NEURON_RELU_EN
  localparam logic [3:0] EXP_RELU = 4'b0000;
`else
  localparam logic [3:0] EXP_RELU = 4'b1101;
`endif

  // Instance A: N_INPUTS = 4
  logic       start_a = 1'b0;
  logic [3:0] bias_a = 4'b0;
  logic       busy_a, rd_en_a, out_valid_a;
  logic [1:0] rd_addr_a;
  logic [3:0] x_a = 4'b0, w_a = 4'b0, out_data_a;
  logic       out_ready_a = 1'b0;
  logic [3:0] xmem_a [0:3];
  logic [3:0] wmem_a [0:3];

  // Instance B: N_INPUTS = 1
  logic       start_b = 1'b0;
  logic [3:0] bias_b = 4'b0;
  logic       busy_b, rd_en_b, out_valid_b;
  logic [0:0] rd_addr_b;
  logic [3:0] x_b = 4'b0, w_b = 4'b0, out_data_b;
  logic       out_ready_b = 1'b0;
  logic [3:0] xmem_b [0:1];
  logic [3:0] wmem_b [0:1];

  neuron_seq_ctrl #(.N_INPUTS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bias_in(bias_a),
    .busy(busy_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .x_rd_data(x_a), .w_rd_data(w_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  neuron_seq_ctrl #(.N_INPUTS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bias_in(bias_b),
    .busy(busy_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .x_rd_data(x_b), .w_rd_data(w_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  // Synchronous-read buffer models: data appears the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en_a) begin
      x_a <= xmem_a[rd_addr_a];
      w_a <= wmem_a[rd_addr_a];
    end
    if (rd_en_b) begin
      x_b <= xmem_b[rd_addr_b];
      w_b <= wmem_b[rd_addr_b];
    end
  end

  task automatic fill_a(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      xmem_a[i] = v;
      wmem_a[i] = v;
    end
  endtask

  // Starts a job on A at cycle 0 and walks to the falling edge of cycle 1 (start dropped)
  task automatic kick_a(input logic [3:0] bias);
    @(negedge clk);
    start_a = 1'b1;
    bias_a  = bias;
    @(negedge clk);
    start_a = 1'b0;
    bias_a  = 4'b0;
  endtask

  // Completes an output handshake on A with no new start
  task automatic drain_a();
    out_ready_a = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    compared++;
    if (busy_a !== 1'b0 || rd_en_a !== 1'b0 || out_valid_a !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl_a: got busy=%b rd_en=%b out_valid=%b expected 0 0 0", busy_a, rd_en_a, out_valid_a);
    end
    compared++;
    if (rd_addr_a !== 2'd0 || out_data_a !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_data_a: got rd_addr=%0d out_data=%b expected 0 0000", rd_addr_a, out_data_a);
    end
    compared++;
    if (busy_b !== 1'b0 || rd_en_b !== 1'b0 || out_valid_b !== 1'b0 || out_data_b !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_b: got busy=%b rd_en=%b out_valid=%b out_data=%b expected 0 0 0 0000", busy_b, rd_en_b, out_valid_b, out_data_b);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_release_a: got busy=%b rd_en=%b expected 0 0", busy_a, rd_en_a);
    end
  endtask

  task automatic test_basic();
    fill_a(4'b0010);
    @(negedge clk);
    start_a = 1'b1;
    bias_a  = 4'b0001;
    #1;
    compared++;
    if (rd_en_a !== 1'b1 || rd_addr_a !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL basic_read_c0: got rd_en=%b rd_addr=%0d expected 1 0", rd_en_a, rd_addr_a);
    end
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      bias_a  = 4'b0;
      #1;
      compared++;
      if (busy_a !== 1'b1 || rd_en_a !== 1'b1 || rd_addr_a !== 2'(c)) begin
        mismatched++;
        $display("[TB] FAIL basic_read_c%0d: got busy=%b rd_en=%b rd_addr=%0d expected 1 1 %0d", c, busy_a, rd_en_a, rd_addr_a, c);
      end
    end
    @(negedge clk);
    #1;
    compared++;
    if (rd_en_a !== 1'b0 || out_valid_a !== 1'b0 || busy_a !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_c4: got rd_en=%b out_valid=%b busy=%b expected 0 0 1", rd_en_a, out_valid_a, busy_a);
    end
    @(negedge clk);
    #1;
    compared++;
    if (out_valid_a !== 1'b1 || out_data_a !== 4'b0101) begin
      mismatched++;
      $display("[TB] FAIL basic_result_c5: got out_valid=%b out_data=%b expected 1 0101", out_valid_a, out_data_a);
    end
    drain_a();
    #1;
    compared++;
    if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_handshake: got out_valid=%b busy=%b expected 0 0", out_valid_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    fill_a(4'b0010);
    kick_a(4'b0001);
    repeat (4) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      compared++;
      if (out_valid_a !== 1'b1 || out_data_a !== 4'b0101) begin
        mismatched++;
        $display("[TB] FAIL stall_hold_%0d: got out_valid=%b out_data=%b expected 1 0101", s, out_valid_a, out_data_a);
      end
    end
    out_ready_a = 1'b1;
    start_a     = 1'b1;
    bias_a      = 4'b0000;
    #1;
    compared++;
    if (rd_en_a !== 1'b1 || rd_addr_a !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL b2b_accept_read: got rd_en=%b rd_addr=%0d expected 1 0", rd_en_a, rd_addr_a);
    end
    @(negedge clk);
    out_ready_a = 1'b0;
    start_a     = 1'b0;
    #1;
    compared++;
    if (busy_a !== 1'b1 || out_valid_a !== 1'b0 || rd_en_a !== 1'b1 || rd_addr_a !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL b2b_no_bubble: got busy=%b out_valid=%b rd_en=%b rd_addr=%0d expected 1 0 1 1", busy_a, out_valid_a, rd_en_a, rd_addr_a);
    end
    repeat (4) @(negedge clk);
    #1;
    compared++;
    if (out_valid_a !== 1'b1 || out_data_a !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL b2b_result: got out_valid=%b out_data=%b expected 1 0100", out_valid_a, out_data_a);
    end
    drain_a();
  endtask

  task automatic test_start_while_busy();
    fill_a(4'b0010);
    kick_a(4'b0001);
    @(negedge clk);
    start_a = 1'b1;
    bias_a  = 4'b0111;
    #1;
    compared++;
    if (rd_addr_a !== 2'd2 || rd_en_a !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL busy_start_c2: got rd_en=%b rd_addr=%0d expected 1 2", rd_en_a, rd_addr_a);
    end
    @(negedge clk);
    start_a = 1'b0;
    bias_a  = 4'b0;
    #1;
    compared++;
    if (rd_addr_a !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL busy_start_c3: got rd_addr=%0d expected 3", rd_addr_a);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    compared++;
    if (out_valid_a !== 1'b1 || out_data_a !== 4'b0101) begin
      mismatched++;
      $display("[TB] FAIL busy_start_result: got out_valid=%b out_data=%b expected 1 0101", out_valid_a, out_data_a);
    end
    drain_a();
  endtask

  task automatic test_reset_mid_run();
    fill_a(4'b0010);
    kick_a(4'b0011);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (busy_a !== 1'b0 || rd_en_a !== 1'b0 || rd_addr_a !== 2'd0 || out_valid_a !== 1'b0 || out_data_a !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset: got busy=%b rd_en=%b rd_addr=%0d out_valid=%b out_data=%b expected 0 0 0 0 0000", busy_a, rd_en_a, rd_addr_a, out_valid_a, out_data_a);
    end
    @(negedge clk);
    rst = 1'b0;
    kick_a(4'b0001);
    repeat (4) @(negedge clk);
    #1;
    compared++;
    if (out_valid_a !== 1'b1 || out_data_a !== 4'b0101) begin
      mismatched++;
      $display("[TB] FAIL midrun_fresh_result: got out_valid=%b out_data=%b expected 1 0101", out_valid_a, out_data_a);
    end
    drain_a();
  endtask

  // Single-pair job on instance B; returns after the handshake
  task automatic run_single_b(input string name, input logic [3:0] bias,
                              input logic [3:0] xw, input logic [3:0] expected);
    xmem_b[0] = xw;
    wmem_b[0] = xw;
    @(negedge clk);
    start_b = 1'b1;
    bias_b  = bias;
    #1;
    compared++;
    if (rd_en_b !== 1'b1 || rd_addr_b !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_read: got rd_en=%b rd_addr=%0d expected 1 0", name, rd_en_b, rd_addr_b);
    end
    @(negedge clk);
    start_b = 1'b0;
    #1;
    compared++;
    if (rd_en_b !== 1'b0 || busy_b !== 1'b1 || out_valid_b !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_c1: got rd_en=%b busy=%b out_valid=%b expected 0 1 0", name, rd_en_b, busy_b, out_valid_b);
    end
    @(negedge clk);
    #1;
    compared++;
    if (out_valid_b !== 1'b1 || out_data_b !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s_result: got out_valid=%b out_data=%b expected 1 %b", name, out_valid_b, out_data_b, expected);
    end
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
    #1;
    compared++;
    if (busy_b !== 1'b0 || out_valid_b !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_handshake: got busy=%b out_valid=%b expected 0 0", name, busy_b, out_valid_b);
    end
  endtask

  task automatic test_wrap();
    run_single_b("wrap", 4'b0110, 4'b0100, 4'b0010);
  endtask

  task automatic test_relu();
    run_single_b("relu", 4'b1100, 4'b0010, EXP_RELU);
  endtask

  // Runs every scenario in order, then prints the summary
  initial begin
    for (int i = 0; i < 2; i++) begin
      xmem_b[i] = 4'b0;
      wmem_b[i] = 4'b0;
    end
    fill_a(4'b0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    test_wrap();
    test_relu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
